// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
// FSM encoding, decode field positions, PC step.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 28;
    localparam int unsigned FN_MSB  = 3;
    localparam int unsigned FN_LSB  = 0;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter with step, redirect and alignment.
// Ports: clk, rst, inc, redir_valid, redir_target -> pc, misalign_err.
module if_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_target,
    output logic [ADDR_W-1:0] pc,
    output logic              misalign_err
);

    logic misal;

    assign misal = |redir_target[1:0];

    // Redirect beats the sequential step; the
    // target is forced to word alignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redir_valid && misal;
            if (redir_valid) begin
                pc <= {redir_target[ADDR_W-1:2], 2'b00};
            end else if (inc) begin
                pc <= pc + ADDR_W'(PC_INC);
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, one-outstanding imem fetch, decode hand-off.
// Ports: imem req/rsp, redirect, if_* to decode, misalign_err, fetch_count.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned        CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [3:0]         if_opcode,
    output logic [3:0]         if_fncode,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus4,
    output logic               misalign_err,
    output logic [CNT_W-1:0]   fetch_count
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic              discard;
    logic              discard_nxt;
    logic              latch;
    logic              pc_inc;
    logic              deliver;
    logic [ADDR_W-1:0] pc;

    if_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk          (clk),
        .rst          (rst),
        .inc          (pc_inc),
        .redir_valid  (redirect_valid),
        .redir_target (redirect_target),
        .pc           (pc),
        .misalign_err (misalign_err)
    );

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        latch       = 1'b0;
        pc_inc      = 1'b0;
        deliver     = 1'b0;
        unique case (state)
            ST_REQ: begin
                // A stale response still owed from before
                // a reset retires the discard here.
                if (imem_rsp_valid && discard) begin
                    discard_nxt = 1'b0;
                end
                if (imem_req_ready) begin
                    state_nxt = ST_WAIT;
                    if (redirect_valid) begin
                        discard_nxt = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (discard || redirect_valid) begin
                        discard_nxt = 1'b0;
                        state_nxt   = ST_REQ;
                    end else begin
                        latch     = 1'b1;
                        pc_inc    = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    discard_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                deliver = if_ready;
                if (if_ready || redirect_valid) begin
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_REQ;
            // Reset during WAIT leaves a response in
            // flight; remember to drop it.
            discard     <= (state == ST_WAIT)
                        || (discard && !imem_rsp_valid);
            if_instr    <= '0;
            if_pc       <= '0;
            fetch_count <= '0;
        end else begin
            state   <= state_nxt;
            discard <= discard_nxt;
            if (latch) begin
                if_instr <= imem_rsp_data;
                if_pc    <= pc;
            end
            if (deliver) begin
                fetch_count <= fetch_count + 1'b1;
            end
        end
    end

    assign imem_req_valid = (state == ST_REQ) && !rst;
    assign imem_addr      = pc;
    assign if_valid       = (state == ST_HOLD) && !rst;
    assign if_opcode      = if_instr[OPC_MSB:OPC_LSB];
    assign if_fncode      = if_instr[FN_MSB:FN_LSB];
    assign if_pc_plus4    = if_pc + ADDR_W'(PC_INC);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an
// in-order memory model and a delivery scoreboard.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [3:0]  if_opcode;
    logic [3:0]  if_fncode;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        misalign_err;
    logic [15:0] fetch_count;

    instr_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_opcode       (if_opcode),
        .if_fncode       (if_fncode),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .misalign_err    (misalign_err),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exq[$];
    int          total;
    int          bad;
    int          ncyc;
    int          lat;
    int          exp_cnt;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h10) return 32'h6000_0001;
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // One clock: score a decode handshake, capture a
    // request handshake, then update the memory model.
    task automatic cyc();
        logic        acc;
        logic [31:0] aa;
        logic [31:0] e;
        logic [31:0] w;
        mreq_t       m;
        if (if_valid && if_ready) begin
            if (exq.size() == 0) begin
                chk("dlv_unexp", if_pc, 32'hFFFF_FFFF);
            end else begin
                e = exq.pop_front();
                w = word(e);
                chk("dlv_pc", if_pc, e);
                chk("dlv_instr", if_instr, w);
                chk("dlv_opc", 32'(if_opcode), 32'(w[31:28]));
                chk("dlv_fn", 32'(if_fncode), 32'(w[3:0]));
                chk("dlv_pc4", if_pc_plus4, e + 32'd4);
                chk("dlv_cnt", 32'(fetch_count), 32'(exp_cnt));
                exp_cnt++;
            end
        end
        acc = imem_req_valid && imem_req_ready;
        aa  = imem_addr;
        @(posedge clk);
        ncyc++;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        if (acc) mq.push_back('{aa, ncyc + lat - 1});
        if (mq.size() > 0 && mq[0].due <= ncyc) begin
            m = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(m.addr);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exq.size() > 0 && n < budget) begin
            cyc();
            n++;
        end
        chk("drain", 32'(exq.size()), 32'd0);
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            cyc();
            n++;
        end
        chk("req_wait", 32'(imem_req_valid), 32'd1);
    endtask

    task automatic wait_ifv();
        int n;
        n = 0;
        while (!if_valid && n < 20) begin
            cyc();
            n++;
        end
        chk("ifv_wait", 32'(if_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        ncyc = 0;
        lat = 1;
        exp_cnt = 0;
        rst = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        if_ready = 1'b1;
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_req", 32'(imem_req_valid), 32'd0);
        chk("rst_ifv", 32'(if_valid), 32'd0);
        chk("rst_cnt", 32'(fetch_count), 32'd0);
        chk("rst_ifpc", if_pc, 32'd0);
        chk("rst_mis", 32'(misalign_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_req1", 32'(imem_req_valid), 32'd1);
        chk("rst_addr", imem_addr, 32'd0);

        // sequential stream
        exq.push_back(32'h0);
        exq.push_back(32'h4);
        exq.push_back(32'h8);
        exq.push_back(32'hC);
        drain(60);

        // hold under back-pressure
        if_ready = 1'b0;
        wait_ifv();
        for (int i = 0; i < 5; i++) begin
            chk("hold_v", 32'(if_valid), 32'd1);
            chk("hold_opc", 32'(if_opcode), 32'd6);
            chk("hold_fn", 32'(if_fncode), 32'd1);
            chk("hold_req", 32'(imem_req_valid), 32'd0);
            chk("hold_pc", if_pc, 32'h10);
            cyc();
        end
        chk("hold_cnt", 32'(fetch_count), 32'd4);
        exq.push_back(32'h10);
        if_ready = 1'b1;
        drain(20);

        // redirect in WAIT, slow memory
        lat = 3;
        wait_req();
        cyc();
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        cyc();
        redirect_valid = 1'b0;
        chk("r100_mis", 32'(misalign_err), 32'd0);
        exq.push_back(32'h100);
        wait_req();
        chk("r100_addr", imem_addr, 32'h100);
        drain(40);

        // redirect in REQ without accept, then
        // redirect on the accept cycle
        lat = 1;
        imem_req_ready = 1'b0;
        wait_req();
        redirect_valid = 1'b1;
        redirect_target = 32'h8;
        cyc();
        chk("r8_req", 32'(imem_req_valid), 32'd1);
        chk("r8_addr", imem_addr, 32'h8);
        imem_req_ready = 1'b1;
        redirect_target = 32'h40;
        cyc();
        redirect_valid = 1'b0;
        exq.push_back(32'h40);
        wait_req();
        chk("r40_addr", imem_addr, 32'h40);
        drain(40);

        // misaligned target
        redirect_valid = 1'b1;
        redirect_target = 32'h202;
        cyc();
        redirect_valid = 1'b0;
        chk("mis_on", 32'(misalign_err), 32'd1);
        cyc();
        chk("mis_off", 32'(misalign_err), 32'd0);
        exq.push_back(32'h200);
        wait_req();
        chk("mis_addr", imem_addr, 32'h200);
        drain(40);

        // redirect during HOLD with a handshake
        if_ready = 1'b0;
        wait_ifv();
        chk("hr_pc", if_pc, 32'h204);
        exq.push_back(32'h204);
        if_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h300;
        cyc();
        redirect_valid = 1'b0;
        chk("hr_ifv", 32'(if_valid), 32'd0);
        chk("hr_cnt", 32'(fetch_count), 32'(exp_cnt));
        exq.push_back(32'h300);
        wait_req();
        chk("hr_addr", imem_addr, 32'h300);
        drain(40);

        // reset while waiting on a slow response
        lat = 4;
        wait_req();
        cyc();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        cyc();
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        chk("wr_cnt", 32'(fetch_count), 32'd0);
        chk("wr_ifv", 32'(if_valid), 32'd0);
        chk("wr_addr", imem_addr, 32'd0);
        for (int n = 0; n < 20 && mq.size() > 0; n++) begin
            cyc();
        end
        chk("wr_stale", 32'(mq.size()), 32'd0);
        lat = 1;
        imem_req_ready = 1'b1;
        exq.push_back(32'h0);
        wait_req();
        chk("wr_addr2", imem_addr, 32'd0);
        drain(40);
        chk("wr_cnt2", 32'(fetch_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
